iir_biquad_sched: RTL
=====================

Name: iir_biquad_sched

Overview:
Time-multiplexed controller for a cascade of NUM_SEC direct-form-I biquad sections that share one 18x18 multiplier and accumulator. It accepts one sample per valid/ready handshake and runs the 5 taps of each section in sequence. It keeps the per-section history registers and owns a coefficient register file that can be written when the block is idle. It sits between the sample source (ADC decimator) and downstream consumers, and replaces per-section hard-wired multipliers.

Parameters:
NUM_SEC, 4, number of cascaded biquad sections (1..8)
DW, 18, sample width, signed
CW, 18, coefficient width, signed
SHIFT, 16, coefficient fractional bits; result = acc >>> SHIFT
ACC_W, 40, accumulator width, signed
AW, $clog2(5*NUM_SEC), coefficient address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
clr  in  1  synchronous state clear / abort
din  in  DW  input sample, signed
din_valid  in  1  input sample valid
din_ready  out  1  high only in IDLE
dout  out  DW  filtered output, registered
dout_valid  out  1  one-cycle pulse with new dout
cfg_we  in  1  coefficient write strobe
cfg_addr  in  AW  sec*5+tap; taps 0..4 = b0,b1,b2,a1,a2
cfg_wdata  in  CW  coefficient value
cfg_ready  out  1  high only in IDLE; writes are honoured only then
sat_err  out  1  sticky saturation flag

Behaviour:
- Reset (rst low, asynchronous): state IDLE, dout=0, dout_valid=0, sat_err=0, all history regs x1/x2/y1/y2=0. Coefficients reset to identity: b0=2^SHIFT, all others 0.
- States: IDLE -> MAC -> STORE -> (MAC for the next section | DONE) -> IDLE.
- IDLE: din_ready=cfg_ready=1. A rising edge with din_valid=1 latches din into cur, sets sec=0 and tap=0, and moves to MAC. With no din_valid, stay in IDLE.
- cfg_we in IDLE writes coef[cfg_addr]. Writes with cfg_addr >= 5*NUM_SEC are ignored. cfg_we outside IDLE is ignored and not queued. If cfg_we and an accepted din arrive in the same cycle, the write lands first and the sample uses the new coefficient.
- MAC (5 cycles, tap 0..4): multiplier operands are (b0,cur), (b1,x1), (b2,x2), (a1,y1), (a2,y2).
  - tap 0 loads acc = product.
  - taps 1 and 2 add the product.
  - taps 3 and 4 subtract the product.
  - Products are sign-extended to ACC_W.
- STORE (1 cycle):
  - y = acc >>> SHIFT, floor rounding, narrowed to DW (see Optional Feature).
  - Section sec updates x2<=x1, x1<=cur, y2<=y1, y1<=y; then cur<=y.
  - If sec < NUM_SEC-1: sec++ and go to MAC. Otherwise go to DONE.
- DONE: dout<=cur, dout_valid=1 for exactly this cycle, then IDLE.
- Timing:
  - Accept at edge 0. Section k MAC runs on cycles 6k+1..6k+5 and STORE on 6k+6.
  - dout_valid is high on cycle 6*NUM_SEC+1.
  - Minimum sample period is 6*NUM_SEC+2 cycles.
- clr (synchronous, any state): zeroes all history and cur, returns to IDLE, suppresses dout_valid. dout holds its last value and coefficients are kept. clr beats din_valid in the same cycle.
- dout holds its value between pulses.

Optional Feature:
IIR_SAT_EN
- Defined: if the shifted acc is outside [-2^(DW-1), 2^(DW-1)-1], it clamps to the nearest limit and sets sat_err. sat_err clears only on reset or clr.
- Undefined: y = acc[SHIFT+DW-1:SHIFT] (two's-complement wrap) and sat_err is tied to 0.

Decomposition:
- Package iir_sched_pkg: state enum (IDLE, MAC, STORE, DONE), tap index constants (TAP_B0..TAP_A2), TAPS_PER_SEC=5, identity coefficient constant.
- Sub-module iir_mac: multiplier, load/add/subtract accumulator, and shift plus saturate/wrap stage.
- Sequencing, history registers and the coefficient file stay in the top level.

Test Plan:
1. Identity after reset, NUM_SEC=4. din=12345, then -7 -> dout=12345, then -7, each on cycle 25 after its accept; din_ready low for cycles 1..25.
2. Single section, NUM_SEC=1, with b0=78401, b1=0, b2=-78401, a1=-31496, a2=9456. Impulse 1000, 0, 0 -> dout=1196, 574, -1094.
3. Saturation, NUM_SEC=1, b0=131071, din=131071. With IIR_SAT_EN -> dout=131071 and sat_err=1. Without it -> dout=-4 and sat_err=0.
4. clr on cycle 8 of an active sample -> no dout_valid, IDLE next cycle. A following din=100 with identity coefficients -> dout=100 (history cleared).
5. cfg_we while busy (addr 0, data 0) -> ignored; next sample still passes with identity. cfg_addr=5*NUM_SEC in IDLE -> no coefficient changes.
6. din_valid held high continuously -> accepts spaced exactly 6*NUM_SEC+2 cycles apart; one dout_valid per accepted sample.

Source files
------------

// File: rtl/iir_biquad_sched_pkg.sv
// Shared types and constants for the time-multiplexed biquad cascade controller.
package iir_sched_pkg;

  typedef enum logic [1:0] {IDLE, MAC, STORE, DONE} state_t;
  typedef enum logic [1:0] {OP_LOAD, OP_ADD, OP_SUB} mac_op_t;

  typedef logic [2:0] tap_t;

  localparam int   TAPS_PER_SEC = 5;
  localparam tap_t TAP_B0 = 3'd0;
  localparam tap_t TAP_B1 = 3'd1;
  localparam tap_t TAP_B2 = 3'd2;
  localparam tap_t TAP_A1 = 3'd3;
  localparam tap_t TAP_A2 = 3'd4;

  // Identity section: b0 = 1.0 in the coefficient fixed-point format, all other taps 0.
  function automatic logic signed [31:0] ident_coef(input int tap, input int shift);
    return (tap == int'(TAP_B0)) ? (32'sd1 <<< shift) : 32'sd0;
  endfunction

endpackage

// File: rtl/iir_biquad_sched_if.sv
// Sample stream and coefficient-port bundle for iir_biquad_sched.
interface iir_biquad_sched_if #(
  parameter int DW = 18,
  parameter int CW = 18,
  parameter int AW = 5
);
  logic signed [DW-1:0] din;
  logic                 din_valid;
  logic                 din_ready;
  logic signed [DW-1:0] dout;
  logic                 dout_valid;
  logic                 cfg_we;
  logic [AW-1:0]        cfg_addr;
  logic signed [CW-1:0] cfg_wdata;
  logic                 cfg_ready;
  logic                 sat_err;

  modport master (
    output din, din_valid, cfg_we, cfg_addr, cfg_wdata,
    input  din_ready, dout, dout_valid, cfg_ready, sat_err
  );

  modport slave (
    input  din, din_valid, cfg_we, cfg_addr, cfg_wdata,
    output din_ready, dout, dout_valid, cfg_ready, sat_err
  );
endinterface

// File: rtl/iir_biquad_sched_mac.sv
// Shared 18x18 multiplier with load/add/subtract accumulator and output scaling.
// Define IIR_SAT_EN to clamp the scaled result instead of wrapping it.
module iir_mac
  import iir_sched_pkg::*;
#(
  parameter int DW    = 18,
  parameter int CW    = 18,
  parameter int SHIFT = 16,
  parameter int ACC_W = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  mac_op_t              op,
  input  logic signed [CW-1:0] coef,
  input  logic signed [DW-1:0] sample,
  output logic signed [DW-1:0] y,
  output logic                 sat
);
  localparam int PW = CW + DW;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc;

  assign prod     = PW'(coef) * PW'(sample);
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc <= '0;
    end else if (en) begin
      case (op)
        OP_LOAD: acc <= prod_ext;
        OP_ADD:  acc <= acc + prod_ext;
        default: acc <= acc - prod_ext;
      endcase
    end
  end

`ifdef IIR_SAT_EN
  localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;
  assign shifted = acc >>> SHIFT;

  always_comb begin
    y   = shifted[DW-1:0];
    sat = 1'b0;
    if (shifted > Y_MAX) begin
      y   = Y_MAX[DW-1:0];
      sat = 1'b1;
    end else if (shifted < Y_MIN) begin
      y   = Y_MIN[DW-1:0];
      sat = 1'b1;
    end
  end
`else
  logic unused_acc;
  assign unused_acc = ^{acc[ACC_W-1:SHIFT+DW], acc[SHIFT-1:0]};
  assign y   = acc[SHIFT+DW-1:SHIFT];
  assign sat = 1'b0;
`endif

endmodule

// File: rtl/iir_biquad_sched.sv
// Cascade of NUM_SEC direct-form-I biquads sharing one MAC, six cycles per section.
// Define IIR_SAT_EN for saturating output with a sticky sat_err flag.
module iir_biquad_sched
  import iir_sched_pkg::*;
#(
  parameter int NUM_SEC = 4,
  parameter int DW      = 18,
  parameter int CW      = 18,
  parameter int SHIFT   = 16,
  parameter int ACC_W   = 40,
  parameter int AW      = $clog2(TAPS_PER_SEC * NUM_SEC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  iir_biquad_sched_if.slave  bus
);
  localparam int NCOEF = TAPS_PER_SEC * NUM_SEC;
  localparam int SW    = (NUM_SEC > 1) ? $clog2(NUM_SEC) : 1;
  localparam int HSZ   = 1 << SW;

  state_t               state, state_nx;
  logic [SW-1:0]        sec;
  tap_t                 tap;
  logic                 last_sec, last_tap;
  logic signed [DW-1:0] cur;
  logic signed [DW-1:0] x1 [HSZ];
  logic signed [DW-1:0] x2 [HSZ];
  logic signed [DW-1:0] y1 [HSZ];
  logic signed [DW-1:0] y2 [HSZ];
  logic signed [CW-1:0] coef [NCOEF];
  logic [AW-1:0]        coef_idx;
  logic signed [CW-1:0] mac_coef;
  logic signed [DW-1:0] mac_sample, y;
  logic                 mac_en, sat;
  mac_op_t              mac_op;
  logic signed [DW-1:0] dout_q;
  logic                 dout_valid_q, sat_err_q;

  assign last_sec = (sec == SW'(NUM_SEC - 1));
  assign last_tap = (tap == TAP_A2);

  assign bus.din_ready  = (state == IDLE);
  assign bus.cfg_ready  = (state == IDLE);
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.sat_err    = sat_err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    mac_en   = 1'b0;
    mac_op   = OP_LOAD;
    if (clr) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:  if (bus.din_valid) state_nx = MAC;
        MAC: begin
          mac_en = 1'b1;
          if (tap == TAP_B0)      mac_op = OP_LOAD;
          else if (tap <= TAP_B2) mac_op = OP_ADD;
          else                    mac_op = OP_SUB;
          if (last_tap) state_nx = STORE;
        end
        STORE:   state_nx = last_sec ? DONE : MAC;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Operand select: tap order b0*cur, b1*x1, b2*x2, a1*y1, a2*y2.
  always_comb begin
    coef_idx = AW'(int'(sec) * TAPS_PER_SEC + int'(tap));
    mac_coef = coef[coef_idx];
    case (tap)
      TAP_B0:  mac_sample = cur;
      TAP_B1:  mac_sample = x1[sec];
      TAP_B2:  mac_sample = x2[sec];
      TAP_A1:  mac_sample = y1[sec];
      default: mac_sample = y2[sec];
    endcase
  end

  iir_mac #(
    .DW    (DW),
    .CW    (CW),
    .SHIFT (SHIFT),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .en     (mac_en),
    .op     (mac_op),
    .coef   (mac_coef),
    .sample (mac_sample),
    .y      (y),
    .sat    (sat)
  );

  // NOTE: the coefficient file is flops, not RAM, so it can take an async reset to identity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec          <= '0;
      tap          <= TAP_B0;
      cur          <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      sat_err_q    <= 1'b0;
      for (int i = 0; i < HSZ; i++) begin
        x1[i] <= '0;
        x2[i] <= '0;
        y1[i] <= '0;
        y2[i] <= '0;
      end
      for (int i = 0; i < NCOEF; i++) coef[i] <= CW'(ident_coef(i % TAPS_PER_SEC, SHIFT));
    end else begin
      dout_valid_q <= 1'b0;
      // A write in the accept cycle lands before the first MAC cycle reads it.
      if (state == IDLE && bus.cfg_we && int'(bus.cfg_addr) < NCOEF)
        coef[bus.cfg_addr] <= bus.cfg_wdata;
      if (clr) begin
        cur       <= '0;
        sat_err_q <= 1'b0;
        for (int i = 0; i < HSZ; i++) begin
          x1[i] <= '0;
          x2[i] <= '0;
          y1[i] <= '0;
          y2[i] <= '0;
        end
      end else begin
        case (state)
          IDLE: if (bus.din_valid) begin
            cur <= bus.din;
            sec <= '0;
            tap <= TAP_B0;
          end
          MAC: tap <= tap + 3'd1;
          STORE: begin
            x2[sec] <= x1[sec];
            x1[sec] <= cur;
            y2[sec] <= y1[sec];
            y1[sec] <= y;
            cur     <= y;
            tap     <= TAP_B0;
            if (sat) sat_err_q <= 1'b1;
            if (last_sec) begin
              dout_q       <= y;
              dout_valid_q <= 1'b1;
            end else begin
              sec <= sec + SW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
